// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, divider FSM states and the datapath width.
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2,
        DIV = 3'd3,
        RSH = 3'd4,
        LSH = 3'd5,
        BOR = 3'd6,
        BAN = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor
// with a parallel-prefix carry-lookahead adder and keep the difference if no borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);
    localparam int LVLS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_gp;
    logic [WIDTH-1:0] w_pp;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    assign w_shift = {i_rem, i_bit};
    assign w_g     = w_shift[WIDTH-1:0] & ~i_divisor;
    assign w_p     = w_shift[WIDTH-1:0] ^ ~i_divisor;

    always_comb begin : prefix
        logic [WIDTH-1:0] gg, pp, gn, pn;
        int j;
        gg = w_g;
        pp = w_p;
        j  = 0;
        for (int s = 0; s < LVLS; s++) begin
            gn = gg;
            pn = pp;
            for (int i = 0; i < WIDTH; i++) begin
                j = (i >= (1 << s)) ? i - (1 << s) : i;
                if (i >= (1 << s)) begin
                    gn[i] = gg[i] | (pp[i] & gg[j]);
                    pn[i] = pp[i] & pp[j];
                end
            end
            gg = gn;
            pp = pn;
        end
        w_gp = gg;
        w_pp = pp;
    end

    // Carry-in of 1 completes the two's-complement subtract.
    assign w_carry = {w_gp | w_pp, 1'b1};
    assign w_sum   = w_p ^ w_carry[WIDTH-1:0];

    // The extra top bit of the shifted remainder pairs with a zero divisor bit,
    // so the final carry stage reduces to an OR.
    assign o_qbit = w_shift[WIDTH] | w_carry[WIDTH];
    assign o_rem  = o_qbit ? w_sum : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider returning {remainder, quotient}.
//   IDLE | waiting for an operand pair      ITER | one quotient bit per cycle
//   FIX  | apply result signs, load out     DONE | result held until taken
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               div_by_zero
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t         r_state;
    div_state_t         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [2*WIDTH-1:0] r_out;
    logic               r_dbz;

    logic               w_accept;
    logic               w_b_zero;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_step_rem;
    logic               w_step_q;

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign out         = r_out;
    assign div_by_zero = r_dbz;

    assign w_accept = in_valid && in_ready;
    assign w_b_zero = (b == '0);
    assign w_a_neg  = is_signed && a[WIDTH-1];
    assign w_b_neg  = is_signed && b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // The dividend shifts out of r_quo MSB-first while quotient bits fill in at the LSB.
    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_quo[WIDTH-1]),
        .i_divisor (r_div),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = w_b_zero ? DONE : ITER;
            ITER:    if (r_cnt == '0) w_state_next = FIX;
            FIX:     w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_out    <= '0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dbz <= w_b_zero;
                        if (w_b_zero) begin
                            r_out <= {a, {WIDTH{1'b1}}};
                        end else begin
                            r_quo    <= w_a_mag;
                            r_div    <= w_b_mag;
                            r_rem    <= '0;
                            r_sign_q <= w_a_neg ^ w_b_neg;
                            r_sign_r <= w_a_neg;
                            r_cnt    <= CNT_W'(WIDTH - 1);
                        end
                    end
                end
                ITER: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[WIDTH-2:0], w_step_q};
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    r_out <= {(r_sign_r ? -r_rem : r_rem), (r_sign_q ? -r_quo : r_quo)};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed corner cases plus randomized operands
// with random result backpressure, checked against a plain-arithmetic model.
module tb_seq_divider;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          is_signed;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out;
    logic          div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2*W-1:0] res;
        logic           dbz;
        int             acc;
        int             lat;
    } exp_t;

    exp_t q[$];
    bit   front_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: b == 0 is flagged; signed divide truncates toward zero, remainder follows dividend.
    function automatic logic [64:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [31:0] qq;
        logic [31:0] rr;
        int sx;
        int sy;
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        if (!s) begin
            qq = x / y;
            rr = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            qq = 32'h8000_0000;
            rr = 32'd0;
        end else begin
            sx = $signed(x);
            sy = $signed(y);
            qq = 32'(sx / sy);
            rr = 32'(sx % sy);
        end
        return {1'b0, rr, qq};
    endfunction

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts);
        bit got;
        int acc;
        logic [64:0] m;
        exp_t e;
        got = 1'b0;
        acc = 0;
        @(posedge clk); #1;
        a = ta; b = tb_; is_signed = ts; in_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        if (!got) begin
            fail("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        m     = model(ta, tb_, ts);
        e.res = m[63:0];
        e.dbz = m[64];
        e.acc = acc;
        e.lat = (tb_ == 32'd0) ? 1 : W + 2;
        q.push_back(e);
        in_valid  = 1'b0;
        a         = $urandom;
        b         = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        if (!ok) fail("out_valid_timeout");
    endtask

    // Monitor: latency on first sight, result held stable every cycle until the handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    fail("unexpected_result");
                end else begin
                    if (!front_seen) begin
                        check("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
                        front_seen = 1'b1;
                    end
                    check("out", out, q[0].res);
                    check("div_by_zero", 64'(div_by_zero), 64'(q[0].dbz));
                    check("in_ready_done", 64'(in_ready), 64'd0);
                    if (out_ready) begin
                        void'(q.pop_front());
                        front_seen = 1'b0;
                    end
                end
            end else if (q.size() > 0) begin
                check("in_ready_busy", 64'(in_ready), 64'd0);
            end
        end
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out", out, 64'd0);
        check("reset_dbz", 64'(div_by_zero), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(32'd100, 32'd7, 1'b0);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1);
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1);
        do_op(32'd5, 32'd0, 1'b0);
        do_op(32'd9, 32'd3, 1'b0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op(32'hFFFF_FFF9, 32'd0, 1'b1);

        // Backpressure: hold the result, poke in_valid, then release and go back-to-back.
        do_op(32'd1234567, 32'd89, 1'b0);
        out_ready = 1'b0;
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            a         = $urandom;
            b         = $urandom;
            is_signed = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        do_op(32'd99999, 32'd123, 1'b0);

        // Reset in the middle of ITER drops the operation.
        do_op(32'd12345, 32'd67, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        front_seen = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out", out, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(32'd1000, 32'd10, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 15);
                3:       rb = ra;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            rs = 1'($urandom_range(0, 1));
            do_op(ra, rb, rs);
            out_ready = 1'b0;
            wait_valid();
            repeat ($urandom_range(0, 4)) @(negedge clk);
            @(posedge clk); #1;
            out_ready = 1'b1;
        end

        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) fail("drain_timeout");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
